// File: rtl/func_poly_seq.sv
// func_poly_seq: iterative evaluator of y = a*b + b^3 (or a*b, or b^3 alone).
// A single shift-add multiplier is time-shared across up to three products
// (a*b, b*b, b*b*b), sequenced by a small FSM. Inputs use start/busy and the
// result uses a valid/ready handshake, so y_o holds under backpressure.
module func_poly_seq #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [1:0]     mode_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           busy_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [3*W:0]   y_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_AB  = 3'd1,
    ST_MUL_BB  = 3'd2,
    ST_MUL_BBB = 3'd3,
    ST_ADD     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t             state_r;
  state_t             state_s;

  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic [1:0]         mode_r;
  logic [CW-1:0]      cnt_r;
  logic [3*W-1:0]     acc_r;
  logic [2*W-1:0]     p_ab_r;
  logic [2*W-1:0]     sq_r;
  logic [3*W-1:0]     cube_r;
  logic [3*W:0]       y_r;
  logic               valid_r;
  logic               busy_r;

  logic               last_s;
  logic [3*W-1:0]     mcand_s;
  logic [3*W-1:0]     term_s;
  logic [3*W-1:0]     sum_s;
  logic [2*W-1:0]     pab_term_s;
  logic [3*W-1:0]     cube_term_s;
  logic [3*W:0]       y_next_s;

  assign last_s      = (cnt_r == CW'(W - 1));
  assign busy_o      = busy_r;
  assign out_valid_o = valid_r;
  assign y_o         = y_r;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the multiplier bit-step counter drives phase changes.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s = (mode_i == 2'b10) ? ST_MUL_BB : ST_MUL_AB;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL_AB: begin
        if (last_s) begin
          state_s = (mode_r == 2'b01) ? ST_ADD : ST_MUL_BB;
        end else begin
          state_s = ST_MUL_AB;
        end
      end
      ST_MUL_BB: begin
        if (last_s) begin
          state_s = ST_MUL_BBB;
        end else begin
          state_s = ST_MUL_BB;
        end
      end
      ST_MUL_BBB: begin
        if (last_s) begin
          state_s = ST_ADD;
        end else begin
          state_s = ST_MUL_BBB;
        end
      end
      ST_ADD: begin
        state_s = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Shared shift-add step: the multiplier is always b, only the multiplicand changes.
  always_comb begin
    mcand_s = '0;
    case (state_r)
      ST_MUL_AB:  mcand_s = (3*W)'(a_r);
      ST_MUL_BB:  mcand_s = (3*W)'(b_r);
      ST_MUL_BBB: mcand_s = (3*W)'(sq_r);
      default:    mcand_s = '0;
    endcase
    if (b_r[cnt_r]) begin
      term_s = mcand_s << cnt_r;
    end else begin
      term_s = '0;
    end
    sum_s = acc_r + term_s;
  end

  // Final sum; the term not selected by the mode is forced to zero so stale
  // products from an earlier job never leak into the result.
  always_comb begin
    if (mode_r == 2'b10) begin
      pab_term_s = '0;
    end else begin
      pab_term_s = p_ab_r;
    end
    if (mode_r == 2'b01) begin
      cube_term_s = '0;
    end else begin
      cube_term_s = cube_r;
    end
    y_next_s = (3*W+1)'(pab_term_s) + (3*W+1)'(cube_term_s);
  end

  // Datapath registers: operand capture, accumulation, product storage, handshake.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_r     <= '0;
      b_r     <= '0;
      mode_r  <= 2'b00;
      cnt_r   <= '0;
      acc_r   <= '0;
      p_ab_r  <= '0;
      sq_r    <= '0;
      cube_r  <= '0;
      y_r     <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            a_r    <= a_i;
            b_r    <= b_i;
            mode_r <= mode_i;
            busy_r <= 1'b1;
            cnt_r  <= '0;
            acc_r  <= '0;
          end
        end
        ST_MUL_AB, ST_MUL_BB, ST_MUL_BBB: begin
          if (last_s) begin
            cnt_r <= '0;
            acc_r <= '0;
            if (state_r == ST_MUL_AB) begin
              p_ab_r <= sum_s[2*W-1:0];
            end else if (state_r == ST_MUL_BB) begin
              sq_r <= sum_s[2*W-1:0];
            end else begin
              cube_r <= sum_s;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
            acc_r <= sum_s;
          end
        end
        ST_ADD: begin
          y_r     <= y_next_s;
          valid_r <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready_i) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_func_poly_seq.sv
// Self-checking bench for func_poly_seq (W=8): vector table plus hand-written
// sequences for backpressure, mid-operation reset and back-to-back jobs.
module tb_func_poly_seq;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [1:0]     mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [3*W:0]   y;

  int checks   = 0;
  int failures = 0;

  logic [3*W:0] exp_q[$];

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3*W:0] y;
    int           lat;
    int           hold;
    bit           disturb;
  } vec_t;

  vec_t vecs[8];

  func_poly_seq #(.W(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .mode_i      (mode),
    .a_i         (a),
    .b_i         (b),
    .busy_o      (busy),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .y_o         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Pop the scoreboard and compare against the DUT result.
  task automatic sb_compare(input string name);
    logic [3*W:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(y), 64'(e));
    end
  endtask

  // Wait (bounded) for out_valid; returns edges counted since the call point.
  task automatic wait_valid(input bit disturb, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (disturb) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        mode  = 2'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic run_job(input string name, input vec_t v);
    int lat;
    logic [3*W:0] y_seen;
    @(negedge clk);
    start     = 1'b1;
    mode      = v.mode;
    a         = v.a;
    b         = v.b;
    out_ready = (v.hold == 0);
    exp_q.push_back(v.y);
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    wait_valid(v.disturb, lat);
    check({name, "_latency"}, 64'(lat), 64'(v.lat));
    sb_compare({name, "_y"});
    y_seen = y;
    for (int i = 0; i < v.hold; i++) begin
      if (v.disturb) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
      end
      @(posedge clk); #1;
      check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({name, "_hold_y"}, 64'(y), 64'(y_seen));
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({name, "_busy_drop"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{mode: 2'b00, a: 8'd3,   b: 8'd2,   y: 25'd14,       lat: 25, hold: 0, disturb: 1'b0};
    vecs[1] = '{mode: 2'b00, a: 8'd255, b: 8'd255, y: 25'd16646400, lat: 25, hold: 0, disturb: 1'b0};
    vecs[2] = '{mode: 2'b01, a: 8'd200, b: 8'd100, y: 25'd20000,    lat: 9,  hold: 0, disturb: 1'b0};
    vecs[3] = '{mode: 2'b10, a: 8'd99,  b: 8'd7,   y: 25'd343,      lat: 17, hold: 0, disturb: 1'b0};
    vecs[4] = '{mode: 2'b11, a: 8'd3,   b: 8'd2,   y: 25'd14,       lat: 25, hold: 0, disturb: 1'b0};
    vecs[5] = '{mode: 2'b00, a: 8'd0,   b: 8'd0,   y: 25'd0,        lat: 25, hold: 0, disturb: 1'b0};
    vecs[6] = '{mode: 2'b00, a: 8'd4,   b: 8'd5,   y: 25'd145,      lat: 25, hold: 5, disturb: 1'b1};
    vecs[7] = '{mode: 2'b01, a: 8'd255, b: 8'd255, y: 25'd65025,    lat: 9,  hold: 2, disturb: 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 2'b00;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    #12;
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_y",     64'(y),         64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset dropped between edges while the b*b phase is running.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; a = 8'd5; b = 8'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  64'(busy),      64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_y",     64'(y),         64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job("post_rst", '{mode: 2'b00, a: 8'd1, b: 8'd1, y: 25'd2, lat: 25, hold: 0, disturb: 1'b0});

    // Back-to-back: start held high across the first handshake.
    @(negedge clk);
    start = 1'b1; mode = 2'b01; a = 8'd10; b = 8'd20; out_ready = 1'b1;
    exp_q.push_back(25'd200);
    @(posedge clk); #1;
    mode = 2'b10; a = 8'd50; b = 8'd3;
    exp_q.push_back(25'd27);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat1", 64'(lat), 64'd9);
    sb_compare("b2b_y1");
    @(posedge clk); #1;
    check("b2b_idle_busy",  64'(busy),      64'd0);
    check("b2b_idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("b2b_accept2", 64'(busy), 64'd1);
    start = 1'b0;
    wait_valid(1'b0, lat);
    check("b2b_lat2", 64'(lat), 64'd17);
    sb_compare("b2b_y2");
    @(posedge clk); #1;
    check("b2b_done_valid", 64'(out_valid), 64'd0);
    check("b2b_sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/func_poly_seq.md
Name: func_poly_seq

Overview:
- Parametrised iterative evaluator of f(a,b) = a*b + b^3, with selectable sub-modes a*b and b^3.
- Replaces the separate multiplier/pow3/adder arrangement with one shared shift-add multiplier sequenced by an FSM.
- Uses a start/busy input handshake and a valid/ready output handshake, so results hold under backpressure.
- Sits between the operand source and the result consumer in the functional datapath.

Parameters:
- W, 8, operand width in bits (W >= 2).
- CW, $clog2(W), bit-step counter width (derived; do not override).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request; accepted only in IDLE.
- mode_i  input  2  00: a*b+b^3; 01: a*b; 10: b^3; 11: treated as 00.
- a_i  input  W  unsigned operand a.
- b_i  input  W  unsigned operand b.
- busy_o  output  1  high from accepting edge until the output handshake completes.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- y_o  output  3W+1  unsigned result, full precision, never truncated.

Behaviour:
- Reset: on rst_i=0, immediately and regardless of clock, clear all registers. State=IDLE, busy_o=0, out_valid_o=0, y_o=0. Reset may be applied mid-operation; the in-flight job is discarded.
- Capture: in IDLE with start_i=1, a_i, b_i and mode_i are registered at the edge, and busy_o=1 from the next cycle. Operands are not re-sampled afterwards.
- Multiplier: one shared shift-add unit; acc += (bit cnt of multiplier) ? multiplicand<<cnt : 0, one bit per cycle, W cycles per product.
- States:
  - IDLE: wait for start. Mode 00/01/11 -> MUL_AB; mode 10 -> MUL_BB. cnt=0 and acc=0 on entry.
  - MUL_AB: multiplicand a, multiplier b, W cycles; product stored in p_ab (2W). Then mode 01 -> ADD, otherwise -> MUL_BB.
  - MUL_BB: b*b over W cycles, stored in sq (2W) -> MUL_BBB.
  - MUL_BBB: sq*b over W cycles (multiplicand 2W, multiplier b), stored in cube (3W) -> ADD.
  - ADD: one cycle. y_o <= p_ab + cube, zero-extended to 3W+1, with the unused term forced to 0 per mode. out_valid_o <= 1 -> DONE.
  - DONE: y_o and out_valid_o held stable. On out_ready_i=1: out_valid_o <= 0, busy_o <= 0 -> IDLE.
- Latency (accepting edge to first cycle with out_valid_o=1):
  - Mode 00/11: 3W+1 edges.
  - Mode 01: W+1 edges.
  - Mode 10: 2W+1 edges.
  - Deterministic and independent of operand values; there is no zero-skip.
- Handshake rules:
  - start_i is ignored whenever state != IDLE, including DONE.
  - start_i and out_ready_i high together in DONE: the handshake completes and start is ignored; the requester must hold start_i into IDLE.
  - out_ready_i is ignored when out_valid_o=0.
  - out_valid_o never deasserts without a handshake, except on reset.
- Width: the maximum result (2^W-1)^2 + (2^W-1)^3 < 2^(3W+1), so there is no overflow for any W.
- Counter wraps 0..W-1; the transition occurs on the cycle cnt==W-1 is processed.

Test Plan:
- W=8, mode 00, a=3, b=2, out_ready_i=1 -> y_o=14, out_valid_o rises exactly 25 cycles after the accepting edge, high for 1 cycle.
- W=8, mode 00, a=255, b=255 -> y_o=16646400 (65025+16581375), no truncation.
- W=8, mode 01, a=200, b=100 -> y_o=20000 after 9 cycles; mode 10, b=7, a=99 -> y_o=343 after 17 cycles; mode 11 with a=3, b=2 -> 14 after 25 cycles.
- Backpressure: out_ready_i=0 for 5 cycles after valid -> y_o and out_valid_o stable. start_i pulsed with new operands during the hold and during compute is ignored. The handshake completes on the ready cycle and returns to IDLE.
- Reset: drop rst_i mid-MUL_BB, asynchronously between edges -> busy_o, out_valid_o and y_o go to 0 immediately. After release, a=1, b=1, mode 00 -> y_o=2 after 25 cycles.
- Back-to-back: two jobs with start_i held high across the handshake -> the second job is accepted on the first IDLE cycle and both results are correct in order.
